mult_share_arb: RTL and testbench

- Sequences and time-shares one combinational WIDTH x WIDTH array multiplier between two requesters.
- Arbitrates round-robin and drives registered operands to the multiplier.
- Captures the product one cycle later and returns it with the requester ID over a valid/ready response channel.
- Sits between requesting datapath blocks and a single multiplier instance.

---
 rtl/mult_share_arb_if.sv | 46 ++++
 rtl/mult_share_arb.sv | 129 ++++++++++++
 tb/tb_mult_share_arb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_if.sv
// Request, response and shared-multiplier signals between the arbiter
// and its environment. The slave modport is the arbiter's view.
interface mult_share_arb_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req0_ready;

    logic               req1_valid;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               req1_ready;

    logic [WIDTH-1:0]   mul_x;
    logic [WIDTH-1:0]   mul_y;
    logic [2*WIDTH-1:0] mul_p;

    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [2*WIDTH-1:0] resp_p;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output mul_x, mul_y,
        input  mul_p,
        output resp_valid, resp_id, resp_p,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  mul_x, mul_y,
        output mul_p,
        input  resp_valid, resp_id, resp_p,
        output resp_ready
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin time-sharing of one combinational multiplier between two
// requesters: IDLE grants and registers operands, MUL lets the product
// settle, RESP holds the captured product until the consumer takes it.
module mult_share_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_share_arb_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [WIDTH-1:0]   mul_x_q, mul_x_d;
    logic [WIDTH-1:0]   mul_y_q, mul_y_d;
    logic               resp_id_q, resp_id_d;
    logic [2*WIDTH-1:0] resp_p_q, resp_p_d;
    logic               resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               gnt_valid;
    logic               gnt_id;

    // State and datapath registers, cleared asynchronously so an in-flight result is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            resp_id_q    <= 1'b0;
            resp_p_q     <= '0;
            resp_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
            resp_valid_q <= resp_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // Grant selection: only in IDLE; the pointer breaks ties
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ptr_q;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = MUL;
            MUL:     state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operands on acceptance, product on leaving MUL, count on handshake
    always_comb begin
        ptr_d        = ptr_q;
        mul_x_d      = mul_x_q;
        mul_y_d      = mul_y_q;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        resp_valid_d = resp_valid_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    mul_x_d   = gnt_id ? bus.req1_a : bus.req0_a;
                    mul_y_d   = gnt_id ? bus.req1_b : bus.req0_b;
                    resp_id_d = gnt_id;
                    ptr_d     = ~gnt_id;
                end
            end
            MUL: begin
                resp_p_d     = bus.mul_p;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    cnt_d        = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output decode
    always_comb begin
        bus.req0_ready = gnt_valid && !gnt_id;
        bus.req1_ready = gnt_valid && gnt_id;
        bus.mul_x      = mul_x_q;
        bus.mul_y      = mul_y_q;
        bus.resp_valid = resp_valid_q;
        bus.resp_id    = resp_id_q;
        bus.resp_p     = resp_p_q;
        busy           = (state_q != IDLE);
        op_count       = cnt_q;
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a response scoreboard.
module tb_mult_share_arb;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    mult_share_arb_if #(.WIDTH(WIDTH)) bus();

    // Shared combinational multiplier
    assign bus.mul_p = (2*WIDTH)'(bus.mul_x) * (2*WIDTH)'(bus.mul_y);

    mult_share_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [2*WIDTH:0]   sbq[$];
    logic [2*WIDTH:0]   exp_e;
    logic [CNT_W-1:0]   exp_cnt = '0;
    logic [WIDTH-1:0]   sa[3];
    logic [WIDTH-1:0]   sb[3];
    logic [2*WIDTH-1:0] sp[3];
    int                 last_cyc;

    function automatic logic [2*WIDTH-1:0] prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (2*WIDTH)'(a) * (2*WIDTH)'(b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (!bus.resp_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(n < 20), 1);
    endtask

    task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        #1;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            step();
            n++;
        end
        check("grant_timeout", 32'(n < 20), 1);
        step();
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
        wait_resp("resp_timeout");
        step();
    endtask

    // Scoreboard: push on request acceptance, pop on response handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            exp_cnt = '0;
        end else begin
            check("op_count", op_count, exp_cnt);
            check("ready_excl", bus.req0_ready & bus.req1_ready, 0);
            check("ready_busy", busy & (bus.req0_ready | bus.req1_ready), 0);
            if (bus.req0_valid && bus.req0_ready)
                sbq.push_back({1'b0, prod(bus.req0_a, bus.req0_b)});
            if (bus.req1_valid && bus.req1_ready)
                sbq.push_back({1'b1, prod(bus.req1_a, bus.req1_b)});
            if (bus.resp_valid && bus.resp_ready) begin
                check("sb_nonempty", 32'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    exp_e = sbq.pop_front();
                    check("resp_id", bus.resp_id, exp_e[2*WIDTH]);
                    check("resp_p", bus.resp_p, exp_e[2*WIDTH-1:0]);
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();

        // Reset values
        check("rst_mul_x", bus.mul_x, 0);
        check("rst_mul_y", bus.mul_y, 0);
        check("rst_resp_p", bus.resp_p, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Single requester 10*3
        bus.req0_a = 4'd10; bus.req0_b = 4'd3; bus.req0_valid = 1'b1;
        #1;
        check("t1_ready0", bus.req0_ready, 1);
        check("t1_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_mul_x", bus.mul_x, 10);
        check("t1_mul_y", bus.mul_y, 3);
        check("t1_valid_mul", bus.resp_valid, 0);
        step();
        check("t1_valid", bus.resp_valid, 1);
        check("t1_p", bus.resp_p, 30);
        check("t1_id", bus.resp_id, 0);
        step();
        check("t1_count", op_count, 1);
        check("t1_valid_done", bus.resp_valid, 0);
        check("t1_idle", busy, 0);

        // Contention from reset
        rst_n = 1'b0;
        bus.req0_a = 4'd10; bus.req0_b = 4'd2; bus.req0_valid = 1'b1;
        bus.req1_a = 4'd4;  bus.req1_b = 4'd12; bus.req1_valid = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("c_ready0", bus.req0_ready, 1);
        check("c_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        step();
        check("c_p0", bus.resp_p, 20);
        check("c_id0", bus.resp_id, 0);
        step();
        check("c_ready1_next", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        step();
        check("c_p1", bus.resp_p, 48);
        check("c_id1", bus.resp_id, 1);
        step();
        bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_valid = 1'b1;
        bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_valid = 1'b1;
        #1;
        check("c_rr_ready0", bus.req0_ready, 1);
        check("c_rr_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_resp("c_rr_timeout");
        check("c_rr_id", bus.resp_id, 0);
        step();

        // Backpressure on 15*15 with requester 1 waiting
        bus.resp_ready = 1'b0;
        bus.req0_a = 4'd15; bus.req0_b = 4'd15; bus.req0_valid = 1'b1;
        #1;
        check("bp_ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_a = 4'd7; bus.req1_b = 4'd7; bus.req1_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.resp_valid, 1);
            check("bp_p", bus.resp_p, 225);
            check("bp_id", bus.resp_id, 0);
            check("bp_ready1", bus.req1_ready, 0);
            step();
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_ready1_resp", bus.req1_ready, 0);
        step();
        check("bp_done_valid", bus.resp_valid, 0);
        check("bp_ready1_idle", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        wait_resp("bp_r1_timeout");
        check("bp_r1_p", bus.resp_p, 49);
        step();

        // Stream on requester 1
        sa[0] = 4'd10; sa[1] = 4'd11; sa[2] = 4'd0;
        sb[0] = 4'd1;  sb[1] = 4'd1;  sb[2] = 4'd7;
        sp[0] = 8'd10; sp[1] = 8'd11; sp[2] = 8'd0;
        last_cyc = 0;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            bus.req1_a = sa[i]; bus.req1_b = sb[i];
            #1;
            if (i > 0) begin
                check("s_x_hold_idle", bus.mul_x, sa[i-1]);
                check("s_y_hold_idle", bus.mul_y, sb[i-1]);
            end
            while (!bus.req1_ready && n < 20) begin
                step();
                n++;
            end
            check("s_grant_timeout", 32'(n < 20), 1);
            if (i > 0) check("s_gap", 32'(cyc - last_cyc), 3);
            last_cyc = cyc;
            step();
            check("s_x_mul", bus.mul_x, sa[i]);
            check("s_y_mul", bus.mul_y, sb[i]);
            step();
            check("s_x_resp", bus.mul_x, sa[i]);
            check("s_p", bus.resp_p, sp[i]);
            check("s_id", bus.resp_id, 1);
            step();
        end
        bus.req1_valid = 1'b0;

        // Reset asserted during MUL
        bus.req0_a = 4'd5; bus.req0_b = 4'd5; bus.req0_valid = 1'b1;
        #1;
        check("r_ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        check("r_in_mul", busy, 1);
        rst_n = 1'b0;
        #1;
        check("r_valid", bus.resp_valid, 0);
        check("r_busy", busy, 0);
        check("r_count", op_count, 0);
        check("r_mul_x", bus.mul_x, 0);
        check("r_resp_p", bus.resp_p, 0);
        step();
        step();
        check("r_valid_held", bus.resp_valid, 0);
        rst_n = 1'b1;
        bus.req0_a = 4'd3; bus.req0_b = 4'd3; bus.req0_valid = 1'b1;
        bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_valid = 1'b1;
        #1;
        check("r_ptr_ready0", bus.req0_ready, 1);
        check("r_ptr_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_resp("r_timeout");
        check("r_p", bus.resp_p, 9);
        check("r_id", bus.resp_id, 0);
        step();

        // Counter wrap with a 2-bit counter
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, 4'(i + 1), 4'd2);
            check("wrap_count", op_count, (i + 1) % 4);
        end

        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
